// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer with a one-word output buffer and a sticky overrun flag.
// Optional feature: define SER_PARITY_EN to append one even-parity bit per frame and report par_err.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun,
    output logic [4:0]       bit_count,
    output logic             par_err
);

`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam logic [4:0] LAST_IDX = 5'(FRAME - 1);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t             r_state;
    logic [FRAME-1:0]   r_shift;
    logic [4:0]         r_count;
    logic [WIDTH-1:0]   r_data;
    logic               r_valid;
    logic               r_ovr;
    logic               r_perr;

    logic [FRAME-1:0]   w_shift;
    logic [WIDTH-1:0]   w_word;
    logic               w_perr;
    logic               w_done;
    logic               w_ovr_set;

    assign w_shift = {r_shift[FRAME-2:0], bit_in};
    assign w_done  = bit_en && (r_count == LAST_IDX);

`ifdef SER_PARITY_EN
    // Parity bit arrives last, so it sits in the LSB; the data word is above it.
    assign w_word = w_shift[FRAME-1:1];
    assign w_perr = ^w_shift;
`else
    assign w_word = w_shift;
    assign w_perr = 1'b0;
`endif

    // A completed word is dropped only when the buffer is held full.
    assign w_ovr_set = w_done && (r_state == S_FULL) && !out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_shift <= '0;
            r_count <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            if (bit_en) begin
                r_shift <= w_shift;
                r_count <= w_done ? 5'd0 : r_count + 5'd1;
            end

            case (r_state)
                S_EMPTY: begin
                    if (w_done) begin
                        r_data  <= w_word;
                        r_perr  <= w_perr;
                        r_valid <= 1'b1;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_done) begin
                        if (out_ready) begin
                            r_data <= w_word;
                            r_perr <= w_perr;
                        end
                    end else if (out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_EMPTY;
                end
            endcase

            if (w_ovr_set)
                r_ovr <= 1'b1;
            else if (clr_ovr)
                r_ovr <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_ovr;
    assign bit_count = r_count;
    assign par_err   = r_perr;

endmodule

// File: tb/tb_serial_deserializer.sv
// Randomized and directed bench for serial_deserializer against a word-level reference model.
// Honors SER_PARITY_EN the same way as the design.
module tb_serial_deserializer;

    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam bit PAR   = 1'b1;
`else
    localparam int FRAME = WIDTH;
    localparam bit PAR   = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             bit_in;
    logic             bit_en;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             overrun;
    logic [4:0]       bit_count;
    logic             par_err;

    int n_cmp;
    int n_bad;

    // Reference model: the frame is a running integer, the buffer a value plus flags.
    int m_cnt;
    int m_acc;
    int m_data;
    bit m_valid;
    bit m_ovr;
    bit m_perr;

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_en    (bit_en),
        .out_ready (out_ready),
        .clr_ovr   (clr_ovr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .overrun   (overrun),
        .bit_count (bit_count),
        .par_err   (par_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_acc = 0; m_data = 0;
        m_valid = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic model_edge(input bit en, input bit b, input bit rdy, input bit clr);
        bit done;
        int word;
        bit perr;
        done = 0; word = 0; perr = 0;
        if (en) begin
            m_acc = m_acc * 2 + int'(b);
            m_cnt = m_cnt + 1;
            if (m_cnt == FRAME) begin
                done = 1;
                word = PAR ? (m_acc / 2) : m_acc;
                perr = PAR ? ($countones(m_acc) % 2 == 1) : 1'b0;
                m_cnt = 0;
                m_acc = 0;
            end
        end
        if (done) begin
            if (m_valid && !rdy) begin
                m_ovr = 1;
            end else begin
                m_data = word; m_perr = perr; m_valid = 1;
                if (clr) m_ovr = 0;
            end
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (clr) m_ovr = 0;
        end
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".data"},  32'(data_out),  32'(m_data));
        check({ctx, ".valid"}, 32'(out_valid), 32'(m_valid));
        check({ctx, ".ovr"},   32'(overrun),   32'(m_ovr));
        check({ctx, ".cnt"},   32'(bit_count), 32'(m_cnt));
        check({ctx, ".perr"},  32'(par_err),   32'(m_perr));
    endtask

    // Drive inputs (called just after a falling edge), clock once, check at the next falling edge.
    task automatic step(input bit en, input bit b, input bit rdy, input bit clr, input string ctx);
        bit_en = en; bit_in = b; out_ready = rdy; clr_ovr = clr;
        @(posedge clock);
        model_edge(en, b, rdy, clr);
        @(negedge clock);
        compare_all(ctx);
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit rdy, input bit last_rdy,
                             input int gap, input bit flip_par, input string ctx);
        logic [WIDTH-1:0] wv;
        bit pb;
        wv = w;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            step(1'b1, wv[i], (PAR == 1'b0 && i == 0) ? last_rdy : rdy, 1'b0, ctx);
            if (!(PAR == 1'b0 && i == 0))
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, rdy, 1'b0, ctx);
        end
        if (PAR) begin
            pb = (^wv) ^ flip_par;
            step(1'b1, pb, last_rdy, 1'b0, ctx);
        end
    endtask

    task automatic apply_reset(input string ctx);
        reset = 1'b0;
        bit_en = 0; bit_in = 0; out_ready = 0; clr_ovr = 0;
        model_reset();
        #1;
        compare_all(ctx);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        compare_all(ctx);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0; bit_en = 0; bit_in = 0; out_ready = 0; clr_ovr = 0;
        model_reset();
        repeat (2) @(negedge clock);
        compare_all("rst");
        reset = 1'b1;
        @(negedge clock);

        // Single word with out_ready high: valid for exactly one cycle.
        send_word(8'hB2, 1'b1, 1'b1, 0, 1'b0, "b2");
        check("b2.word", 32'(data_out), 32'h0000_00B2);
        check("b2.vld1", 32'(out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "b2.drain");
        check("b2.vld0", 32'(out_valid), 32'd0);

        // Two words with out_ready low: second dropped, then cleared.
        send_word(8'hB2, 1'b0, 1'b0, 0, 1'b0, "ovr1");
        send_word(8'h5A, 1'b0, 1'b0, 0, 1'b0, "ovr2");
        check("ovr.hold", 32'(data_out), 32'h0000_00B2);
        check("ovr.flag", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, "clr");
        check("ovr.clr", 32'(overrun), 32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "drain");

        // Accept on the very edge that completes the second word.
        send_word(8'hB2, 1'b0, 1'b0, 0, 1'b0, "rdy1");
        send_word(8'h5A, 1'b0, 1'b1, 0, 1'b0, "rdy2");
        check("rdy.word", 32'(data_out), 32'h0000_005A);
        check("rdy.vld",  32'(out_valid), 32'd1);
        check("rdy.ovr",  32'(overrun),   32'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "drain");

        // Gapped strobes: bit_count checked on every cycle by the model.
        send_word(8'hFF, 1'b1, 1'b1, 2, 1'b0, "gap");
        check("gap.word", 32'(data_out), 32'h0000_00FF);
        step(1'b0, 1'b0, 1'b1, 1'b0, "drain");

        // Reset mid-frame, then a clean word.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "part");
        apply_reset("midrst");
        send_word(8'h0F, 1'b1, 1'b1, 0, 1'b0, "0f");
        check("0f.word", 32'(data_out), 32'h0000_000F);
        step(1'b0, 1'b0, 1'b1, 1'b0, "drain");

        if (PAR) begin
            send_word(8'hB2, 1'b1, 1'b1, 0, 1'b0, "pgood");
            check("pgood.perr", 32'(par_err), 32'd0);
            check("pgood.word", 32'(data_out), 32'h0000_00B2);
            send_word(8'hB2, 1'b1, 1'b1, 0, 1'b1, "pbad");
            check("pbad.perr", 32'(par_err), 32'd1);
            check("pbad.word", 32'(data_out), 32'h0000_00B2);
        end else begin
            check("noparity.perr", 32'(par_err), 32'd0);
        end

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 3) != 0, $urandom % 2, ($urandom % 4) == 0,
                 ($urandom % 16) == 0, "rnd");
            if ($urandom_range(0, 999) == 0) apply_reset("rndrst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: WIDTH, default 8, number of data bits per word (legal range 2..16).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: bit_in  input  1  serial data bit; it is the serial stream produced by the sequence FSM output y_out.
REQ-005 Port: bit_en  input  1  sample strobe; bit_in is sampled only on edges where bit_en=1.
REQ-006 Port: out_ready  input  1  downstream consumer accepts the word when out_valid=1 and out_ready=1.
REQ-007 Port: clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-008 Port: data_out  output  WIDTH  assembled word, MSB = first bit received.
REQ-009 Port: out_valid  output  1  data_out holds an unconsumed word.
REQ-010 Port: overrun  output  1  sticky flag: a completed word was dropped.
REQ-011 Port: bit_count  output  5  number of bits collected in the current frame.
REQ-012 Port: par_err  output  1  parity error qualifier for data_out (see Configuration).

Function
REQ-013 Frame length: F = WIDTH, or WIDTH+1 when PARITY_EN is defined.
REQ-014 Each edge with bit_en=1 shall shift bit_in into the shift register LSB and increment bit_count; edges with bit_en=0 shall leave the shift register and bit_count unchanged.
REQ-015 The edge that samples bit number F shall complete the frame and reset bit_count to 0 on that same edge; the next bit_en starts a new frame with no idle gap required.
REQ-016 Output buffer FSM: two states, EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-017 EMPTY, frame completes -> FULL; data_out is loaded on the completing edge and out_valid=1 on the next cycle, giving a latency of 1 edge from the last bit.
REQ-018 FULL, out_ready=1 and no completion -> EMPTY.
REQ-019 FULL, out_ready=1 and completion on the same edge -> stay FULL, load the new word, no overrun.
REQ-020 FULL, out_ready=0 and completion -> stay FULL, keep the old data_out, drop the new word, and set overrun=1.
REQ-021 data_out and par_err shall be stable while out_valid=1 and out_ready=0.
REQ-022 overrun shall clear when clr_ovr=1; if clr_ovr and a new overrun occur on the same edge, the set shall win.
REQ-023 bit_count shall never exceed F-1 when observed after an edge.

Reset
REQ-024 reset=0 shall immediately force: shift register 0, bit_count 0, data_out 0, out_valid 0, overrun 0, par_err 0, FSM in EMPTY.
REQ-025 Reset asserted mid-frame shall discard the partial frame; the first bit_en after release is bit 1 of a new frame.

Configuration
REQ-026 Macro SER_PARITY_EN.
REQ-027 Defined: frame = WIDTH data bits followed by 1 even-parity bit. The parity bit is not placed in data_out. par_err=1 when the XOR of all F bits is 1, loaded together with data_out. The word is delivered even when parity fails.
REQ-028 Not defined: frame = WIDTH bits. The par_err port is present and held constant 0.

Verification
REQ-029 Without the macro, WIDTH=8: send bits 1,0,1,1,0,0,1,0 with continuous bit_en, out_ready=1 -> data_out=8'hB2 and out_valid=1 for exactly 1 cycle, starting 1 edge after bit 8.
REQ-030 Hold out_ready=0, send two full words 8'hB2 then 8'h5A -> data_out stays 8'hB2 and overrun=1 after the 16th bit. Then clr_ovr=1 for one cycle -> overrun=0.
REQ-031 out_ready=1 exactly on the edge completing the 2nd word (8'h5A) while 8'hB2 is held -> data_out=8'h5A, out_valid stays 1, overrun=0.
REQ-032 Gapped bit_en (1 bit every 3 cycles) for 8'hFF -> bit_count steps 1..7 then 0, and data_out=8'hFF.
REQ-033 Assert reset after 5 bits, release, then send 8'h0F -> data_out=8'h0F, with no leftover bits from the aborted frame.
REQ-034 With SER_PARITY_EN: data 8'hB2 with parity bit 0 -> par_err=0; same data with parity bit 1 -> par_err=1, and data_out=8'hB2 in both cases.
